// File: rtl/music_box_pkg.sv
// music_box_pkg: state codes and timed-state FSM encoding shared by the music box UI blocks.
package music_box_pkg;
  localparam logic [4:0] STATE_DO_NOTHING = 5'd0;
  localparam logic [4:0] STATE_PLAY_SONG0 = 5'd1;
  localparam logic [4:0] STATE_PLAY_SONG1 = 5'd2;
  localparam logic [4:0] STATE_PLAY_SONG2 = 5'd3;
  localparam logic [4:0] STATE_PLAY_SONG3 = 5'd4;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} timed_fsm_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..DIV-1 while enabled, pulsing tick on the last count.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_i,
  input  logic hold_i,
  input  logic clear_i,
  output logic tick_o
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tick_o = enable_i && cnt_q == W'(DIV - 1);
  // a wrap beats hold so a tick landing with pause restarts the phase
  always_comb cnt_d = clear_i ? '0 : tick_o ? '0 : (enable_i && !hold_i) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/music_box_state_timed.sv
// music_box_state_timed: timed UI state with pause/skip, holding completion until the controller leaves.
module music_box_state_timed
  import music_box_pkg::*;
#(
  parameter int STATE_ID = 1,
  parameter int CLK_HZ = 50_000_000,
  parameter int TICK_HZ = 1000,
  parameter int DURATION_TICKS = 5000,
  localparam int COUNTER_W = $clog2(DURATION_TICKS + 1)
) (
  input  logic                 clock_50Mhz,
  input  logic                 reset_n,
  input  logic [4:0]           currentState,
  input  logic                 pause,
  input  logic                 skip,
  output logic                 stateComplete,
  output logic                 active,
  output logic [COUNTER_W-1:0] elapsed,
  output logic [31:0]          debugString
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  if (CLK_HZ % TICK_HZ != 0) begin : g_bad_div
    $error("CLK_HZ must be a multiple of TICK_HZ");
  end
  if (DURATION_TICKS < 1) begin : g_bad_dur
    $error("DURATION_TICKS must be at least 1");
  end
  if (STATE_ID < 0 || STATE_ID > 31) begin : g_bad_id
    $error("STATE_ID must fit in 5 bits");
  end
  timed_fsm_t state_q, state_d;
  logic [COUNTER_W-1:0] elapsed_q, elapsed_d;
  logic match, running, tick;
  assign match = currentState == 5'(STATE_ID);
  assign running = state_q == RUN;
  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk     (clock_50Mhz),
    .rst_n   (reset_n),
    .enable_i(running),
    .hold_i  (pause),
    .clear_i (!match || !(running || state_q == PAUSE)),
    .tick_o  (tick)
  );
  always_comb begin
    state_d = state_q;
    elapsed_d = elapsed_q;
    if (!match) begin
      state_d = IDLE;
      elapsed_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          elapsed_d = '0;
        end
        RUN:
          if (skip) state_d = DONE;
          else if (tick && elapsed_q == COUNTER_W'(DURATION_TICKS - 1)) begin
            state_d = DONE;
            elapsed_d = COUNTER_W'(DURATION_TICKS);
          end else begin
            elapsed_d = tick ? elapsed_q + 1'b1 : elapsed_q;
            state_d = pause ? PAUSE : RUN;
          end
        PAUSE: state_d = skip ? DONE : pause ? PAUSE : RUN;
        default: state_d = DONE;
      endcase
    end
  end
  always_ff @(posedge clock_50Mhz or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      elapsed_q <= '0;
    end else begin
      state_q <= state_d;
      elapsed_q <= elapsed_d;
    end
  assign stateComplete = state_q == DONE;
  assign active = running || state_q == PAUSE;
  assign elapsed = elapsed_q;
  assign debugString = {state_q, 14'b0, 16'(elapsed_q)};
endmodule

// File: tb/tb_music_box_state_timed.sv
// tb_music_box_state_timed: directed vectors and corner sequences for a 10-clock tick, 5-tick duration.
module tb_music_box_state_timed;
  import music_box_pkg::*;
  logic clk = 0, rst_n = 0, pause = 0, skip = 0;
  logic [4:0] cs = 0;
  logic complete, act;
  logic [2:0] el;
  logic [31:0] dbg;
  int passed = 0, total = 0;
  music_box_state_timed #(.STATE_ID(1), .CLK_HZ(1000), .TICK_HZ(100), .DURATION_TICKS(5)) dut (
    .clock_50Mhz  (clk),
    .reset_n      (rst_n),
    .currentState (cs),
    .pause        (pause),
    .skip         (skip),
    .stateComplete(complete),
    .active       (act),
    .elapsed      (el),
    .debugString  (dbg)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] cs;
    logic       pause;
    int         edges;
    timed_fsm_t st;
    logic [2:0] el;
  } vec_t;
  vec_t vecs[9];
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask
  task automatic expect_all(input string nm, input timed_fsm_t st, input logic [2:0] e);
    check({nm, " complete"}, 32'(complete), 32'(st == DONE));
    check({nm, " active"}, 32'(act), 32'(st == RUN || st == PAUSE));
    check({nm, " elapsed"}, 32'(el), 32'(e));
    check({nm, " debug"}, dbg, {st, 14'b0, 13'b0, e});
  endtask
  task automatic to_idle();
    pause = 0;
    skip = 0;
    cs = 0;
    step(1);
  endtask
  initial begin
    vecs[0] = '{5'd1, 1'b0, 1, RUN, 3'd0};
    vecs[1] = '{5'd1, 1'b0, 10, RUN, 3'd1};
    vecs[2] = '{5'd1, 1'b0, 9, RUN, 3'd1};
    vecs[3] = '{5'd1, 1'b0, 1, RUN, 3'd2};
    vecs[4] = '{5'd1, 1'b0, 29, RUN, 3'd4};
    vecs[5] = '{5'd1, 1'b0, 1, DONE, 3'd5};
    vecs[6] = '{5'd1, 1'b0, 20, DONE, 3'd5};
    vecs[7] = '{5'd0, 1'b0, 1, IDLE, 3'd0};
    vecs[8] = '{5'd1, 1'b0, 1, RUN, 3'd0};
    #3;
    expect_all("reset", IDLE, 0);
    #4 rst_n = 1;
    step(1);
    foreach (vecs[i]) begin
      cs = vecs[i].cs;
      pause = vecs[i].pause;
      step(vecs[i].edges);
      expect_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].el);
    end
    to_idle();
    cs = 1;
    step(22);
    pause = 1;
    step(1);
    expect_all("pause enter", PAUSE, 2);
    step(19);
    expect_all("pause hold", PAUSE, 2);
    pause = 0;
    step(1);
    expect_all("pause resume", RUN, 2);
    step(28);
    expect_all("pause edge71", RUN, 4);
    step(1);
    expect_all("pause edge72", DONE, 5);
    to_idle();
    cs = 1;
    step(30);
    skip = 1;
    step(1);
    skip = 0;
    expect_all("skip run", DONE, 2);
    step(5);
    expect_all("skip hold", DONE, 2);
    to_idle();
    cs = 1;
    step(22);
    pause = 1;
    step(3);
    skip = 1;
    step(1);
    skip = 0;
    expect_all("skip pause", DONE, 2);
    to_idle();
    cs = 1;
    step(50);
    skip = 1;
    step(1);
    skip = 0;
    expect_all("tick+skip", DONE, 4);
    to_idle();
    cs = 1;
    step(20);
    pause = 1;
    step(1);
    expect_all("tick+pause", PAUSE, 2);
    pause = 0;
    step(1);
    expect_all("tick+pause resume", RUN, 2);
    step(29);
    expect_all("tick+pause edge51", RUN, 4);
    step(1);
    expect_all("tick+pause edge52", DONE, 5);
    to_idle();
    cs = 1;
    step(40);
    cs = 3;
    step(1);
    expect_all("early exit", IDLE, 0);
    cs = 1;
    step(50);
    expect_all("rerun edge50", RUN, 4);
    step(1);
    expect_all("rerun edge51", DONE, 5);
    to_idle();
    cs = 1;
    step(24);
    expect_all("pre reset", RUN, 2);
    #3 rst_n = 0;
    #1;
    expect_all("async reset", IDLE, 0);
    #2 rst_n = 1;
    step(50);
    expect_all("post reset edge50", RUN, 4);
    step(1);
    expect_all("post reset edge51", DONE, 5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
